// File: rtl/ftdi_tx.sv
// ftdi_tx: FT245 synchronous-FIFO transmit engine with a show-ahead byte buffer and bus turnaround FSM.
module ftdi_tx #(
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_60,
  input  logic              rst,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              flush,
  input  logic              rx_req,
  output logic              tx_bus_busy,
  input  logic              ftdi_txe_n,
  output logic              ftdi_wr_n,
  output logic [7:0]        ftdi_data_out,
  output logic              ftdi_data_oe,
  output logic              ftdi_siwu_n,
  output logic [ADDR_W:0]   level
);
  localparam logic [1:0] IDLE = 2'd0, TURN = 2'd1, WRITE = 2'd2, RELEASE = 2'd3;
  localparam logic [ADDR_W:0] FULL = DEPTH[ADDR_W:0];
  logic [7:0] mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr, wr_ptr;
  logic [ADDR_W:0] count, count_nxt;
  logic [1:0] state, state_nxt;
  logic flush_pend, push, pop, fire;
  assign s_ready = count != FULL;
  assign push = s_valid & s_ready;
  assign ftdi_wr_n = !(state == WRITE && count != 0);
  assign pop = !ftdi_wr_n & !ftdi_txe_n;
  assign count_nxt = count + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};
  assign ftdi_data_oe = state == TURN || state == WRITE;
  assign ftdi_data_out = ftdi_data_oe ? mem[rd_ptr] : 8'h00;
  assign tx_bus_busy = state != IDLE;
  assign fire = state == IDLE && count == 0 && flush_pend;
  assign ftdi_siwu_n = !fire;
  assign level = count;
  // WRITE leaves as soon as the buffer will be empty, so oe drops the cycle after the last byte
  always_comb begin
    state_nxt = state == IDLE  ? ((count != 0 && !ftdi_txe_n && !rx_req) ? TURN : IDLE) :
                state == TURN  ? WRITE :
                state == WRITE ? ((rx_req || count_nxt == 0) ? RELEASE : WRITE) :
                                 IDLE;
  end
  always_ff @(posedge clk_60 or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      flush_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      rd_ptr <= rd_ptr + ADDR_W'(pop);
      wr_ptr <= wr_ptr + ADDR_W'(push);
      flush_pend <= flush | (flush_pend & !fire);
    end
  end
  always_ff @(posedge clk_60) begin
    if (push) mem[wr_ptr] <= s_data;
  end
endmodule
